ysyx_lsu_port: RTL and testbench

- Memory-side responder for the execute unit's load/store request interface.
- Accepts one load request (`exu_ren`) or one committed-store request (`exu_wen`) at a time and performs it as an AXI4-Lite single-beat transaction.
- For loads, aligns and extends the read data before returning it. For stores, generates lane-shifted write data and byte strobes.
- Completion is signalled back to the execute unit with single-cycle `lsu_exu_rvalid` / `lsu_exu_wready` pulses. Sits between the execute unit and the data-side bus interconnect.

---
 rtl/ysyx_lsu_port.sv | 159 +++++++++++++++
 tb/tb_ysyx_lsu_port.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu_port.sv
// rtl/ysyx_lsu_port.sv - LSU bus port: execute-unit load/store requests as AXI4-Lite single beats
// Loads are lane-aligned and extended on return; stores are lane-shifted with byte strobes.
module ysyx_lsu_port #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_pipeline,
    input  logic            exu_ren,
    input  logic [XLEN-1:0] exu_raddr,
    input  logic [4:0]      exu_ralu,
    input  logic            exu_wen,
    input  logic [XLEN-1:0] exu_waddr,
    input  logic [4:0]      exu_walu,
    input  logic [XLEN-1:0] exu_wdata,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_exu_rvalid,
    output logic            lsu_exu_wready,
    output logic            lsu_fault,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic [XLEN-1:0] awaddr,
    output logic            awvalid,
    input  logic            awready,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wstrb,
    output logic            wvalid,
    input  logic            wready,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_RD_DONE, S_WR_REQ, S_WR_RESP, S_WR_DONE
    } state_e;

    state_e          state_q;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic            drop_q;
    logic [XLEN-1:0] shifted_d;
    logic [XLEN-1:0] ext_d;
    logic [3:0]      strb_d;
    logic            drop_now_d;
    logic            unused_ok;

    assign unused_ok  = ^{exu_ralu[4:3], exu_walu[4:2]};
    assign drop_now_d = drop_q | flush_pipeline;

    always_comb begin
        shifted_d = rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_d = {{(XLEN-8){shifted_d[7]}}, shifted_d[7:0]};
            3'b001:  ext_d = {{(XLEN-16){shifted_d[15]}}, shifted_d[15:0]};
            3'b100:  ext_d = {{(XLEN-8){1'b0}}, shifted_d[7:0]};
            3'b101:  ext_d = {{(XLEN-16){1'b0}}, shifted_d[15:0]};
            default: ext_d = shifted_d;
        endcase
    end

    always_comb begin
        case (exu_walu[1:0])
            2'b00:   strb_d = 4'b0001 << exu_waddr[1:0];
            2'b01:   strb_d = 4'b0011 << exu_waddr[1:0];
            default: strb_d = 4'b1111;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            off_q          <= 2'b00;
            funct3_q       <= 3'b000;
            drop_q         <= 1'b0;
            lsu_rdata      <= '0;
            lsu_exu_rvalid <= 1'b0;
            lsu_exu_wready <= 1'b0;
            lsu_fault      <= 1'b0;
            araddr         <= '0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            awaddr         <= '0;
            awvalid        <= 1'b0;
            wdata          <= '0;
            wstrb          <= 4'b0000;
            wvalid         <= 1'b0;
            bready         <= 1'b0;
        end else begin
            lsu_exu_rvalid <= 1'b0;
            lsu_exu_wready <= 1'b0;
            lsu_fault      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    drop_q <= 1'b0;
                    // Committed stores win over loads when both are requested.
                    if (exu_wen) begin
                        awaddr  <= {exu_waddr[XLEN-1:2], 2'b00};
                        wdata   <= exu_wdata << {exu_waddr[1:0], 3'b000};
                        wstrb   <= strb_d;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state_q <= S_WR_REQ;
                    end else if (exu_ren && !flush_pipeline) begin
                        araddr   <= {exu_raddr[XLEN-1:2], 2'b00};
                        off_q    <= exu_raddr[1:0];
                        funct3_q <= exu_ralu[2:0];
                        arvalid  <= 1'b1;
                        state_q  <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (flush_pipeline) drop_q <= 1'b1;
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (flush_pipeline) drop_q <= 1'b1;
                    // A flushed load still drains the bus but reports nothing back.
                    if (rvalid) begin
                        rready         <= 1'b0;
                        lsu_rdata      <= ext_d;
                        lsu_exu_rvalid <= !drop_now_d;
                        lsu_fault      <= (rresp != 2'b00) && !drop_now_d;
                        state_q        <= S_RD_DONE;
                    end
                end
                S_RD_DONE: state_q <= S_IDLE;
                S_WR_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready  <= 1'b1;
                        state_q <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        bready         <= 1'b0;
                        lsu_exu_wready <= 1'b1;
                        lsu_fault      <= (bresp != 2'b00);
                        state_q        <= S_WR_DONE;
                    end
                end
                S_WR_DONE: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_lsu_port.sv
// tb/tb_ysyx_lsu_port.sv - directed plus randomized checks of ysyx_lsu_port against a byte-lane model
module tb_ysyx_lsu_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush_pipeline = 1'b0;
    logic        exu_ren = 1'b0;
    logic [31:0] exu_raddr = '0;
    logic [4:0]  exu_ralu = '0;
    logic        exu_wen = 1'b0;
    logic [31:0] exu_waddr = '0;
    logic [4:0]  exu_walu = '0;
    logic [31:0] exu_wdata = '0;
    logic [31:0] lsu_rdata;
    logic        lsu_exu_rvalid, lsu_exu_wready, lsu_fault;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp;
    logic        bvalid = 1'b0;
    logic        bready;

    int n_checks = 0;
    int n_fail = 0;

    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;
    int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    assign rdata = cfg_rdata;
    assign rresp = cfg_rresp;
    assign bresp = cfg_bresp;

    ysyx_lsu_port dut (
        .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
        .exu_ren(exu_ren), .exu_raddr(exu_raddr), .exu_ralu(exu_ralu),
        .exu_wen(exu_wen), .exu_waddr(exu_waddr), .exu_walu(exu_walu), .exu_wdata(exu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_exu_rvalid(lsu_exu_rvalid), .lsu_exu_wready(lsu_exu_wready),
        .lsu_fault(lsu_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    // Bus slave: each channel answers after its configured number of wait cycles.
    always @(posedge clock) begin
        #2;
        if (!reset) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        end else begin
            if (arvalid) begin arready = (ar_c >= ar_wait); ar_c++; end else begin arready = 0; ar_c = 0; end
            if (rready)  begin rvalid  = (r_c >= r_wait);   r_c++;  end else begin rvalid = 0;  r_c = 0;  end
            if (awvalid) begin awready = (aw_c >= aw_wait); aw_c++; end else begin awready = 0; aw_c = 0; end
            if (wvalid)  begin wready  = (w_c >= w_wait);   w_c++;  end else begin wready = 0;  w_c = 0;  end
            if (bready)  begin bvalid  = (b_c >= b_wait);   b_c++;  end else begin bvalid = 0;  b_c = 0;  end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            if (arvalid && arready) begin ar_hs++; cap_araddr = araddr; end
            if (rvalid && rready) r_hs++;
            if (awvalid && awready) begin aw_hs++; cap_awaddr = awaddr; end
            if (wvalid && wready) begin w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
            if (bvalid && bready) b_hs++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int byte_of(input logic [31:0] w, input int k);
        return int'((longint'(w) / (longint'(1) << (8 * k))) % 256);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int off, n;
        longint v;
        off = int'(a % 4);
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        v = 0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) v += longint'(byte_of(d, off + i)) * (longint'(1) << (8 * i));
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n)) + (longint'(1) << 32);
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] op);
        int off, n;
        logic [3:0] s;
        if (op == 2'd2) return 4'hF;
        off = int'(a % 4);
        n = (op == 2'd0) ? 1 : 2;
        s = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] a, input logic [31:0] d);
        int off;
        longint r;
        off = int'(a % 4);
        r = 0;
        for (int i = 0; i < 4; i++)
            if (i >= off) r += longint'(byte_of(d, i - off)) * (longint'(1) << (8 * i));
        return r[31:0];
    endfunction

    task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] d, input logic [1:0] resp,
                            input int arw, input int rw, input bit do_flush);
        int ar0, r0, pulses, faults, lat, after;
        bit flushed, fault_at;
        logic [31:0] res;
        ar0 = ar_hs; r0 = r_hs; pulses = 0; faults = 0; lat = -1; after = -1;
        flushed = 0; fault_at = 0; res = '0;
        ar_wait = arw; r_wait = rw; cfg_rdata = d; cfg_rresp = resp;
        exu_raddr = a; exu_ralu = {2'b00, f3}; exu_ren = 1;
        for (int n = 1; n <= 80 && after < 4; n++) begin
            @(posedge clock); #1;
            flush_pipeline = 0;
            if (lsu_exu_rvalid) begin
                pulses++;
                if (lat < 0) begin lat = n; res = lsu_rdata; fault_at = lsu_fault; end
                exu_ren = 0;
            end
            if (lsu_fault) faults++;
            if (do_flush && rready && !flushed) begin flush_pipeline = 1; exu_ren = 0; flushed = 1; end
            if (after >= 0) after++;
            else if (r_hs != r0) after = 0;
        end
        exu_ren = 0; flush_pipeline = 0;
        check({tag, "_araddr"}, cap_araddr, a - (a % 4));
        check({tag, "_ar_count"}, 32'(ar_hs - ar0), 32'd1);
        check({tag, "_r_count"}, 32'(r_hs - r0), 32'd1);
        if (do_flush) begin
            check({tag, "_flushed_pulses"}, 32'(pulses), 32'd0);
            check({tag, "_flushed_faults"}, 32'(faults), 32'd0);
        end else begin
            check({tag, "_pulses"}, 32'(pulses), 32'd1);
            check({tag, "_latency"}, 32'(lat), 32'(3 + arw + rw));
            check({tag, "_rdata"}, res, ref_load(a, f3, d));
            check({tag, "_fault"}, {31'd0, fault_at}, 32'(resp != 0));
            check({tag, "_fault_pulses"}, 32'(faults), 32'(resp != 0));
        end
    endtask

    task automatic run_store(input string tag, input logic [31:0] a, input logic [1:0] op,
                             input logic [31:0] d, input logic [1:0] resp,
                             input int aww, input int ww, input int bw);
        int aw0, w0, b0, pulses, faults, lat, after;
        bit fault_at;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; pulses = 0; faults = 0; lat = -1; after = -1; fault_at = 0;
        aw_wait = aww; w_wait = ww; b_wait = bw; cfg_bresp = resp;
        exu_waddr = a; exu_walu = {3'b000, op}; exu_wdata = d; exu_wen = 1;
        for (int n = 1; n <= 80 && after < 4; n++) begin
            @(posedge clock); #1;
            if (lsu_exu_wready) begin
                pulses++;
                if (lat < 0) begin lat = n; fault_at = lsu_fault; end
                exu_wen = 0;
            end
            if (lsu_fault) faults++;
            if (after >= 0) after++;
            else if (b_hs != b0) after = 0;
        end
        exu_wen = 0;
        check({tag, "_awaddr"}, cap_awaddr, a - (a % 4));
        check({tag, "_wdata"}, cap_wdata, ref_wdata(a, d));
        check({tag, "_wstrb"}, {28'd0, cap_wstrb}, {28'd0, ref_strb(a, op)});
        check({tag, "_handshakes"}, 32'((aw_hs - aw0) * 100 + (w_hs - w0) * 10 + (b_hs - b0)), 32'd111);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(3 + ((aww > ww) ? aww : ww) + bw));
        check({tag, "_fault"}, {31'd0, fault_at}, 32'(resp != 0));
        check({tag, "_fault_pulses"}, 32'(faults), 32'(resp != 0));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valids"},
              {24'd0, arvalid, rready, awvalid, wvalid, bready, lsu_exu_rvalid, lsu_exu_wready, lsu_fault},
              32'd0);
    endtask

    initial begin
        logic [2:0]  ld_ops [5];
        logic [31:0] res;
        int w_pulse, first_ar, rv;
        ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset");
        check("reset_rdata", lsu_rdata, 32'd0);
        check("reset_addrs", araddr | awaddr | wdata | {28'd0, wstrb}, 32'd0);
        reset = 1;
        @(posedge clock); #1;

        run_load("lb_zero_wait", 32'h8000_0003, 3'b000, 32'h80FF_1234, 2'b00, 0, 0, 0);
        run_load("lhu_r_delay5", 32'h8000_0002, 3'b101, 32'hBEEF_0000, 2'b00, 0, 5, 0);
        run_store("sh_w_before_aw", 32'h8000_0006, 2'b01, 32'h0000_ABCD, 2'b00, 2, 0, 1);

        // Both requests in the same cycle: the store must run to completion first.
        aw_wait = 0; w_wait = 0; b_wait = 0; cfg_bresp = 0;
        ar_wait = 0; r_wait = 0; cfg_rdata = 32'h1357_9BDF; cfg_rresp = 0;
        exu_waddr = 32'h8000_0100; exu_walu = 5'd2; exu_wdata = 32'hCAFE_F00D;
        exu_raddr = 32'h8000_0200; exu_ralu = 5'd2;
        exu_wen = 1; exu_ren = 1;
        w_pulse = -1; first_ar = -1; rv = -1; res = '0;
        for (int n = 1; n <= 80 && rv < 0; n++) begin
            @(posedge clock); #1;
            if (lsu_exu_wready && w_pulse < 0) begin w_pulse = n; exu_wen = 0; end
            if (arvalid && first_ar < 0) first_ar = n;
            if (lsu_exu_rvalid) begin rv = n; res = lsu_rdata; exu_ren = 0; end
        end
        exu_ren = 0; exu_wen = 0;
        check("both_store_done", 32'(w_pulse > 0), 32'd1);
        check("both_ar_after_wready", 32'(first_ar), 32'(w_pulse + 2));
        check("both_load_data", res, 32'h1357_9BDF);
        repeat (3) @(posedge clock);
        #1;

        run_load("lw_flush", 32'h8000_0010, 3'b010, 32'h1111_2222, 2'b00, 1, 2, 1);
        run_load("after_flush", 32'h8000_0011, 3'b100, 32'hA5C3_7E19, 2'b00, 0, 0, 0);
        run_store("sw_bresp_err", 32'h8000_0020, 2'b10, 32'h0BAD_F00D, 2'b10, 0, 0, 0);
        run_load("lb_rresp_err", 32'h8000_0031, 3'b000, 32'h0000_7F00, 2'b10, 1, 0, 0);

        // Asynchronous reset while the store waits on its write response.
        aw_wait = 0; w_wait = 0; b_wait = 30; cfg_bresp = 0;
        exu_waddr = 32'h8000_0040; exu_walu = 5'd2; exu_wdata = 32'h1234_5678; exu_wen = 1;
        rv = 0;
        for (int n = 1; n <= 20 && rv == 0; n++) begin
            @(posedge clock); #1;
            if (bready) rv = 1;
        end
        check("rst_reached_wr_resp", 32'(rv), 32'd1);
        exu_wen = 0;
        reset = 0;
        #1;
        check_quiet("rst_mid_wr_resp");
        @(posedge clock); #1;
        reset = 1;
        b_wait = 0;
        @(posedge clock); #1;
        run_load("after_reset", 32'h8000_0052, 3'b001, 32'h8001_FFFF, 2'b00, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            logic [31:0] a, d;
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                run_load($sformatf("rnd_ld%0d", k), a, ld_ops[$urandom_range(0, 4)], d,
                         ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                         $urandom_range(0, 3), $urandom_range(0, 3), 0);
            else
                run_store($sformatf("rnd_st%0d", k), a, 2'($urandom_range(0, 2)), d,
                          ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00,
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
